// File: rtl/sd_spi_master_if.sv
// Command/status bundle between the port controller (master side) and the
// SD card SPI engine (slave side).
interface sd_spi_master_if;
    logic       sd_signal;
    logic [1:0] sd_cmd;
    logic [7:0] sd_out;
    logic [7:0] sd_din;
    logic       sd_busy;
    logic       sd_timeout;

    modport master (
        output sd_signal,
        output sd_cmd,
        output sd_out,
        input  sd_din,
        input  sd_busy,
        input  sd_timeout
    );

    modport slave (
        input  sd_signal,
        input  sd_cmd,
        input  sd_out,
        output sd_din,
        output sd_busy,
        output sd_timeout
    );
endinterface

// File: rtl/sd_spi_master.sv
// SD card SPI master (mode 0, MSB first). Commands are issued by toggling
// sd_signal: 0 = 80-clock init burst, 1 = byte exchange, 2 = CS assert,
// 3 = CS release. Tracks runs of 0xFF replies to flag an unresponsive card.
module sd_spi_master #(
    parameter int DIV_INIT      = 32,
    parameter int DIV_FAST      = 2,
    parameter int TIMEOUT_BYTES = 256
) (
    input  logic          clock,
    input  logic          reset_n,
    sd_spi_master_if.slave host,
    output logic          spi_cs,
    output logic          spi_sclk,
    output logic          spi_mosi,
    input  logic          spi_miso
);

    localparam int HALF_MAX = (DIV_INIT > DIV_FAST) ? DIV_INIT : DIV_FAST;
    localparam int HW       = $clog2(HALF_MAX + 1);
    localparam int CW       = $clog2(TIMEOUT_BYTES + 1);

    localparam logic [HW-1:0] INIT_LAST = HW'(DIV_INIT - 1);
    localparam logic [HW-1:0] FAST_LAST = HW'(DIV_FAST - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_XFER,
        S_CSEL,
        S_CSREL
    } state_t;

    state_t        state;
    logic          armed;        // low for the first cycle after reset so sig_seen can resync
    logic          sig_seen;
    logic [HW-1:0] hcnt;         // clocks elapsed in the current SCLK half-period
    logic [2:0]    bcnt;         // bit index within a byte exchange
    logic [6:0]    pcnt;         // SCLK period index during init
    logic [6:0]    tx_rest;      // remaining transmit bits; bit 7 goes straight to MOSI
    logic [7:0]    rx;
    logic [CW-1:0] ff_cnt;
    logic [CW-1:0] ff_cnt_next;

    // Saturating increment of the consecutive-0xFF counter.
    always_comb begin
        ff_cnt_next = ff_cnt;
        if (ff_cnt != CNT_MAX) begin
            ff_cnt_next = ff_cnt + 1'b1;
        end
    end

    // Command detect, SPI sequencing and status flags in one registered FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            armed           <= 1'b0;
            sig_seen        <= 1'b0;
            hcnt            <= '0;
            bcnt            <= '0;
            pcnt            <= '0;
            tx_rest         <= '0;
            rx              <= '0;
            ff_cnt          <= '0;
            spi_cs          <= 1'b1;
            spi_sclk        <= 1'b0;
            spi_mosi        <= 1'b1;
            host.sd_din     <= 8'hFF;
            host.sd_busy    <= 1'b0;
            host.sd_timeout <= 1'b0;
        end else begin
            armed    <= 1'b1;
            sig_seen <= host.sd_signal;

            case (state)
                S_IDLE: begin
                    spi_sclk <= 1'b0;
                    spi_mosi <= 1'b1;
                    hcnt     <= '0;
                    bcnt     <= '0;
                    pcnt     <= '0;
                    if (armed && (host.sd_signal != sig_seen)) begin
                        host.sd_busy <= 1'b1;
                        case (host.sd_cmd)
                            2'd0: begin
                                // Init starts with the high half of the first period.
                                state           <= S_INIT;
                                spi_sclk        <= 1'b1;
                                spi_cs          <= 1'b1;
                                host.sd_timeout <= 1'b0;
                                ff_cnt          <= '0;
                            end
                            2'd1: begin
                                state    <= S_XFER;
                                spi_mosi <= host.sd_out[7];
                                tx_rest  <= host.sd_out[6:0];
                                rx       <= '0;
                            end
                            2'd2: state <= S_CSEL;
                            2'd3: state <= S_CSREL;
                        endcase
                    end
                end

                S_INIT: begin
                    if (hcnt == INIT_LAST) begin
                        hcnt <= '0;
                        if (spi_sclk) begin
                            spi_sclk <= 1'b0;
                        end else if (pcnt == 7'd79) begin
                            host.sd_busy <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            spi_sclk <= 1'b1;
                            pcnt     <= pcnt + 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                S_XFER: begin
                    if (hcnt == FAST_LAST) begin
                        hcnt <= '0;
                        if (!spi_sclk) begin
                            // Rising edge: capture the card's bit.
                            spi_sclk <= 1'b1;
                            rx       <= {rx[6:0], spi_miso};
                        end else if (bcnt == 3'd7) begin
                            spi_sclk     <= 1'b0;
                            spi_mosi     <= 1'b1;
                            host.sd_din  <= rx;
                            host.sd_busy <= 1'b0;
                            state        <= S_IDLE;
                            // Only replies while the card is selected count towards timeout.
                            if (!spi_cs) begin
                                if (rx == 8'hFF) begin
                                    ff_cnt <= ff_cnt_next;
                                    if (ff_cnt_next == CNT_MAX) begin
                                        host.sd_timeout <= 1'b1;
                                    end
                                end else begin
                                    ff_cnt <= '0;
                                end
                            end
                        end else begin
                            // Falling edge: present the next transmit bit.
                            spi_sclk <= 1'b0;
                            spi_mosi <= tx_rest[6];
                            tx_rest  <= {tx_rest[5:0], 1'b0};
                            bcnt     <= bcnt + 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                S_CSEL: begin
                    spi_cs          <= 1'b0;
                    host.sd_timeout <= 1'b0;
                    ff_cnt          <= '0;
                    host.sd_busy    <= 1'b0;
                    state           <= S_IDLE;
                end

                S_CSREL: begin
                    spi_cs       <= 1'b1;
                    host.sd_busy <= 1'b0;
                    state        <= S_IDLE;
                end

                default: begin
                    host.sd_busy <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master: commands push expectations derived
// from a transaction-level card/host model; a monitor checks each completed
// command when sd_busy falls.
module tb_sd_spi_master;

    localparam int DIV_INIT      = 32;
    localparam int DIV_FAST      = 2;
    localparam int TIMEOUT_BYTES = 256;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic spi_cs;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;

    sd_spi_master_if host();

    sd_spi_master #(
        .DIV_INIT      (DIV_INIT),
        .DIV_FAST      (DIV_FAST),
        .TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .host     (host),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clock = ~clock;

    // Card model: shifts out miso_byte MSB first, advancing after each rising SCLK.
    logic [7:0] miso_byte = 8'hFF;
    int         miso_idx  = 0;
    assign spi_miso = (miso_idx < 8) ? miso_byte[3'(7 - miso_idx)] : 1'b1;
    always @(posedge spi_sclk) miso_idx++;

    typedef struct {
        int         cmd;
        logic [7:0] din;
        logic       to;
        int         dur;
        int         rises;
        logic       cs_during;
        logic       cs_after;
        logic [7:0] mosi;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;
    int done_count = 0;

    // Reference model state
    logic       m_cs  = 1'b1;
    logic [7:0] m_din = 8'hFF;
    logic       m_to  = 1'b0;
    int         m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor
    int         busy_cycles = 0;
    int         rises       = 0;
    logic       busy_prev   = 1'b0;
    logic       sclk_prev   = 1'b0;
    logic       cs_hi       = 1'b0;
    logic       cs_lo       = 1'b0;
    logic       mosi_lo     = 1'b0;
    logic [7:0] mosi_bits   = 8'h00;

    always @(negedge clock) begin
        if (!reset_n) begin
            busy_prev = 1'b0;
            sclk_prev = 1'b0;
        end else begin
            if (host.sd_busy && !busy_prev) begin
                busy_cycles = 0;
                rises       = 0;
                cs_hi       = 1'b0;
                cs_lo       = 1'b0;
                mosi_lo     = 1'b0;
                mosi_bits   = 8'h00;
            end
            if (host.sd_busy) begin
                busy_cycles++;
                if (spi_cs) cs_hi = 1'b1;
                else        cs_lo = 1'b1;
                if (!spi_mosi) mosi_lo = 1'b1;
            end
            if (spi_sclk && !sclk_prev) begin
                rises++;
                mosi_bits = {mosi_bits[6:0], spi_mosi};
            end
            if (!host.sd_busy && busy_prev) begin
                check("pending_expect", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn cmd=%0d busy=%0d rises=%0d din=%02h to=%0b cs=%0b mosi=%02h",
                             e.cmd, busy_cycles, rises, host.sd_din, host.sd_timeout, spi_cs, mosi_bits);
                    check("busy_cycles", busy_cycles, e.dur);
                    check("sclk_rises", rises, e.rises);
                    check("sd_din", host.sd_din, e.din);
                    check("sd_timeout", host.sd_timeout, e.to);
                    check("cs_after", spi_cs, e.cs_after);
                    check("idle_sclk", spi_sclk, 0);
                    check("idle_mosi", spi_mosi, 1);
                    if (e.cmd == 0 || e.cmd == 1)
                        check("cs_during", {cs_hi, cs_lo}, e.cs_during ? 2'b10 : 2'b01);
                    if (e.cmd == 0)
                        check("init_mosi_high", mosi_lo, 0);
                    if (e.cmd == 1)
                        check("mosi_stream", mosi_bits, e.mosi);
                end
                done_count++;
            end
            busy_prev = host.sd_busy;
            sclk_prev = spi_sclk;
        end
    end

    task automatic send(input logic [1:0] cmd, input logic [7:0] out, input logic [7:0] card);
        exp_t e;
        @(negedge clock);
        miso_byte      = card;
        miso_idx       = 0;
        host.sd_cmd    = cmd;
        host.sd_out    = out;
        host.sd_signal = ~host.sd_signal;
        e.cmd       = int'(cmd);
        e.cs_during = m_cs;
        e.mosi      = out;
        e.rises     = 0;
        e.dur       = 1;
        case (cmd)
            2'd0: begin
                e.dur = 160 * DIV_INIT; e.rises = 80; e.cs_during = 1'b1;
                m_cs = 1'b1; m_to = 1'b0; m_cnt = 0;
            end
            2'd1: begin
                e.dur = 16 * DIV_FAST; e.rises = 8;
                m_din = card;
                if (!m_cs) begin
                    if (card == 8'hFF) m_cnt = (m_cnt < TIMEOUT_BYTES) ? m_cnt + 1 : m_cnt;
                    else               m_cnt = 0;
                    if (m_cnt == TIMEOUT_BYTES) m_to = 1'b1;
                end
            end
            2'd2: begin m_cs = 1'b0; m_to = 1'b0; m_cnt = 0; end
            default: m_cs = 1'b1;
        endcase
        e.din      = m_din;
        e.to       = m_to;
        e.cs_after = m_cs;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("done_in_time", 32'(done_count >= target), 1);
        if (done_count < target) exp_q.delete();
    endtask

    task automatic run(input logic [1:0] cmd, input logic [7:0] out, input logic [7:0] card);
        int target = done_count + 1;
        send(cmd, out, card);
        wait_done(target, 6000);
    endtask

    task automatic count_busy(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (host.sd_busy) seen++;
        end
    endtask

    initial begin
        int seen;
        int target;
        host.sd_signal = 1'b1;
        host.sd_cmd    = 2'd0;
        host.sd_out    = 8'h00;
        reset_n        = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_cs", spi_cs, 1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 1);
        check("rst_din", host.sd_din, 8'hFF);
        check("rst_busy", host.sd_busy, 0);
        check("rst_timeout", host.sd_timeout, 0);
        reset_n = 1'b1;
        count_busy(30, seen);
        check("no_cmd_after_reset", seen, 0);
        check("idle_cs", spi_cs, 1);

        // Init burst, then a directed exchange
        run(2'd0, 8'h00, 8'hFF);
        run(2'd2, 8'h00, 8'hFF);
        run(2'd1, 8'h40, 8'hA5);

        // Timeout after 256 consecutive 0xFF replies, cleared by cmd 2
        run(2'd2, 8'h00, 8'hFF);
        for (int i = 0; i < TIMEOUT_BYTES; i++) run(2'd1, 8'($urandom), 8'hFF);
        check("timeout_after_256", host.sd_timeout, 1);
        run(2'd2, 8'h00, 8'hFF);
        check("timeout_cleared", host.sd_timeout, 0);

        // A non-FF reply at byte 255 restarts the count
        for (int i = 0; i < TIMEOUT_BYTES - 2; i++) run(2'd1, 8'($urandom), 8'hFF);
        run(2'd1, 8'h77, 8'h01);
        run(2'd1, 8'h11, 8'hFF);
        check("timeout_prevented", host.sd_timeout, 0);

        // Randomised command mix
        for (int i = 0; i < 40; i++) begin
            logic [1:0] c;
            logic [7:0] card;
            c    = 2'($urandom_range(1, 3));
            card = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            run(c, 8'($urandom), card);
        end

        // Toggle while busy: ignored, next toggle after busy accepted
        run(2'd2, 8'h00, 8'hFF);
        target = done_count + 1;
        send(2'd1, 8'hA3, 8'h3C);
        repeat (10) @(negedge clock);
        host.sd_cmd    = 2'd3;
        host.sd_signal = ~host.sd_signal;
        wait_done(target, 200);
        count_busy(40, seen);
        check("ignored_toggle_no_cmd", seen, 0);
        check("ignored_toggle_cs", spi_cs, 0);
        run(2'd1, 8'hC5, 8'h9E);

        // Reset in the middle of an exchange
        send(2'd1, 8'h5A, 8'hC3);
        repeat (16) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort_cs", spi_cs, 1);
        check("abort_sclk", spi_sclk, 0);
        check("abort_mosi", spi_mosi, 1);
        check("abort_busy", host.sd_busy, 0);
        check("abort_din", host.sd_din, 8'hFF);
        exp_q.delete();
        m_cs = 1'b1; m_din = 8'hFF; m_to = 1'b0; m_cnt = 0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        run(2'd1, 8'h96, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sd_spi_master.md
Name: sd_spi_master

Overview:
SPI master for the SD card slot, directly downstream of the memory/port controller. It consumes the command latch (sd_cmd, sd_out, sd_signal) written by the CPU through port 0x3A/0x39. It returns sd_din, sd_busy and sd_timeout, which the controller exposes at ports 0x39 and STATUS[5:4]. It drives the card pins CS/SCLK/MOSI and samples MISO.

Parameters:
DIV_INIT, 32, system clocks per SCLK half-period during the init command (about 400 kHz at 25 MHz).
DIV_FAST, 2, system clocks per SCLK half-period during byte exchange; minimum 1.
TIMEOUT_BYTES, 256, consecutive 0xFF bytes received after CS enable before sd_timeout is set.

Ports:
clock       in   1  system clock; all logic on posedge.
reset_n     in   1  asynchronous active-low reset.
sd_signal   in   1  command strobe; a toggle relative to the last seen value issues a command.
sd_cmd      in   2  command code: 0 = init, 1 = exchange byte, 2 = CS assert, 3 = CS release.
sd_out      in   8  byte to transmit for cmd 1.
sd_din      out  8  last byte received from the card.
sd_busy     out  1  command in progress.
sd_timeout  out  1  sticky card-not-responding flag.
spi_cs      out  1  card chip select, active low.
spi_sclk    out  1  SPI clock (mode 0, idle low).
spi_mosi    out  1  SPI data to card, MSB first.
spi_miso    in   1  SPI data from card.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: spi_cs=1, spi_sclk=0, spi_mosi=1, sd_din=8'hFF, sd_busy=0, sd_timeout=0.
  - Internal: FSM=IDLE, sig_seen=sd_signal sampled at deassertion (no spurious command), FF counter=0.
  - Reset mid-operation aborts the transfer immediately, with pins forced to the reset values.
- Command detect:
  - Each posedge, sig_seen<=sd_signal.
  - A command is accepted when sd_signal!=sig_seen and FSM=IDLE. sd_cmd and sd_out are captured in that same cycle.
  - sd_busy=1 from the next cycle.
  - A toggle seen while busy is ignored, but sig_seen is still updated. Software must poll sd_busy.
- FSM states:
  - IDLE: sd_busy=0, spi_sclk=0.
  - INIT (cmd 0):
    - spi_cs=1, spi_mosi=1.
    - 80 SCLK periods, each DIV_INIT clocks high and DIV_INIT clocks low, 160*DIV_INIT clocks total.
    - Clears sd_timeout and the FF counter.
    - Returns to IDLE; spi_cs stays 1.
  - XFER (cmd 1):
    - shift<=sd_out; spi_mosi=shift[7] valid before the first rising edge.
    - 8 bits, each bit being DIV_FAST clocks low then DIV_FAST clocks high.
    - MISO is sampled into rx on the rising SCLK edge. MOSI shifts to the next bit on the falling edge.
    - After the 8th high phase, SCLK returns low, sd_din<=rx, and FSM=IDLE.
    - Total 16*DIV_FAST clocks of sd_busy.
    - sd_din and sd_busy=0 update in the same cycle.
    - spi_mosi returns to 1 in IDLE.
  - CSEL (cmd 2): spi_cs<=0, clears sd_timeout and the FF counter, 1-cycle busy pulse, then IDLE.
  - CSREL (cmd 3): spi_cs<=1, 1-cycle busy pulse, then IDLE. sd_timeout is unaffected.
- Timeout:
  - At the end of each XFER with spi_cs=0:
    - rx==8'hFF increments the counter (saturating).
    - Any other value clears it.
  - When the counter reaches TIMEOUT_BYTES, sd_timeout<=1 (sticky) until cmd 0, cmd 2 or reset.
  - XFER with spi_cs=1 never affects the counter.
- Half-period counter width: $clog2(max(DIV_INIT,DIV_FAST)+1). Bit counter 3 bits; INIT period counter 7 bits.
- Inputs sd_cmd and sd_out come from negedge-written registers and are stable at the posedge the toggle is detected.

Test Plan:
- Reset, then hold: pins cs=1, sclk=0, mosi=1, sd_din=FF, busy=0, timeout=0. With sd_signal=1 at reset release, no command is issued.
- Toggle with cmd 0 (DIV_INIT=32):
  - Exactly 80 SCLK rising edges, period 64 clocks.
  - cs=1 and mosi=1 throughout.
  - busy high for 5120 clocks.
- cmd 2, then cmd 1 with sd_out=8'h40 and the MISO model returning 8'hA5 (DIV_FAST=2):
  - mosi bit stream 0,1,0,0,0,0,0,0 at rising edges.
  - sd_din=8'hA5 and busy falls 32 clocks after busy rose.
  - cs=0 throughout.
- cmd 2, then 256 exchanges with MISO held 1:
  - sd_timeout rises at the end of the 256th byte.
  - An exchange returning 8'h01 at byte 255 instead prevents it.
  - A subsequent cmd 2 clears the flag.
- Toggle sd_signal mid-XFER:
  - The transfer completes unchanged.
  - No second command runs.
  - The next toggle after busy falls is accepted.
- Assert reset_n=0 at bit 4 of an XFER:
  - Pins return to reset values immediately.
  - busy=0 and sd_din=FF.
  - After release, a new cmd 1 runs a full 8-bit exchange.
